// File: rtl/spike_pkg.sv
// ---------------------------------------------------------------------------
// spike_pkg
// Shared types and helpers for the spike encoder slice.
//   enc_state_t : encoder control state (idle / running a gamma cycle)
//   laneLsb()   : bit offset of a lane's spike-time field in a packed vector
// ---------------------------------------------------------------------------
package spike_pkg;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_RUN  = 1'b1
    } enc_state_t;

    // Lane i's spike time lives in bits [laneLsb(i, w) +: w] of a packed bus.
    function automatic int laneLsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// ---------------------------------------------------------------------------
// spike_encoder_if
// Valid/ready input channel carrying one spike-time vector per transfer.
//   in_valid : source has a vector on in_times/in_mask
//   in_ready : encoder can take a vector this cycle
//   in_times : packed per-lane spike times, TIME_WIDTH bits per lane
//   in_mask  : per-lane fire enable
// master = vector source, slave = encoder.
// ---------------------------------------------------------------------------
interface spike_encoder_if #(
    parameter int NUM_INPUTS = 16,
    parameter int TIME_WIDTH = 4
);

    logic                             in_valid;
    logic                             in_ready;
    logic [NUM_INPUTS*TIME_WIDTH-1:0] in_times;
    logic [NUM_INPUTS-1:0]            in_mask;

    modport master (
        output in_valid,
        output in_times,
        output in_mask,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_times,
        input  in_mask,
        output in_ready
    );

endinterface

// File: rtl/spike_pulse_gen.sv
// ---------------------------------------------------------------------------
// spike_pulse_gen
// One lane of the encoder: raises spike_o while the gamma tick lies in
// [laneTime_i, laneTime_i + PULSE_WIDTH).
//   runEn_i    : encoder is in a gamma cycle
//   laneTime_i : this lane's spike time
//   laneMask_i : this lane fires this gamma cycle
//   tick_i     : current gamma tick
//   spike_o    : pulse output
// ---------------------------------------------------------------------------
module spike_pulse_gen #(
    parameter int TIME_WIDTH  = 4,
    parameter int PULSE_WIDTH = 8
) (
    input  logic                  runEn_i,
    input  logic [TIME_WIDTH-1:0] laneTime_i,
    input  logic                  laneMask_i,
    input  logic [TIME_WIDTH-1:0] tick_i,
    output logic                  spike_o
);

    // The end-of-pulse sum is widened so late spike times cannot wrap back
    // into an early window.
    localparam int SUM_WIDTH = TIME_WIDTH + $clog2(PULSE_WIDTH + 1) + 1;

    logic [SUM_WIDTH-1:0] tickExt;
    logic [SUM_WIDTH-1:0] pulseEnd;

    assign tickExt  = SUM_WIDTH'(tick_i);
    assign pulseEnd = SUM_WIDTH'(laneTime_i) + SUM_WIDTH'(PULSE_WIDTH);

    // Truncation at the gamma boundary falls out naturally: the tick never
    // exceeds the last gamma tick, and the lane is reloaded or idled after it.
    assign spike_o = runEn_i && laneMask_i &&
                     (tick_i >= laneTime_i) && (tickExt < pulseEnd);

endmodule

// File: rtl/spike_encoder.sv
// ---------------------------------------------------------------------------
// spike_encoder
// Converts spike-time vectors into temporal spike pulses, one vector per
// gamma cycle, with a single-entry pending buffer so back-to-back vectors run
// without an idle gap.
//   aclk          : clock
//   rst           : asynchronous active-high reset
//   inBus         : valid/ready vector input (slave side)
//   output_spikes : per-lane spike pulses
//   gamma_start   : high on tick 0 of each active gamma cycle
//   busy          : high while a gamma cycle is running
// ---------------------------------------------------------------------------
module spike_encoder
    import spike_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 16
) (
    input  logic                  aclk,
    input  logic                  rst,
    spike_encoder_if.slave        inBus,
    output logic [NUM_INPUTS-1:0] output_spikes,
    output logic                  gamma_start,
    output logic                  busy
);

    localparam int TIME_WIDTH = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int TIMES_BITS = NUM_INPUTS * TIME_WIDTH;
    localparam logic [TIME_WIDTH-1:0] LAST_TICK = TIME_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    enc_state_t              state_q,        state_d;
    logic [TIME_WIDTH-1:0]   tick_q,         tick_d;
    logic                    pendingValid_q, pendingValid_d;
    logic [TIMES_BITS-1:0]   pendingTimes_q, pendingTimes_d;
    logic [NUM_INPUTS-1:0]   pendingMask_q,  pendingMask_d;
    logic [TIMES_BITS-1:0]   activeTimes_q,  activeTimes_d;
    logic [NUM_INPUTS-1:0]   activeMask_q,   activeMask_d;
    logic                    runState;

    assign inBus.in_ready = !pendingValid_q;

    // Next-state logic. Accepting into pending requires an empty buffer and
    // loading from pending requires a full one, so the two never collide.
    always_comb begin
        state_d        = state_q;
        tick_d         = tick_q;
        pendingValid_d = pendingValid_q;
        pendingTimes_d = pendingTimes_q;
        pendingMask_d  = pendingMask_q;
        activeTimes_d  = activeTimes_q;
        activeMask_d   = activeMask_q;

        if (inBus.in_valid && !pendingValid_q) begin
            pendingValid_d = 1'b1;
            pendingTimes_d = inBus.in_times;
            pendingMask_d  = inBus.in_mask;
        end

        unique case (state_q)
            ENC_IDLE: begin
                tick_d = '0;
                if (pendingValid_q) begin
                    activeTimes_d  = pendingTimes_q;
                    activeMask_d   = pendingMask_q;
                    pendingValid_d = 1'b0;
                    state_d        = ENC_RUN;
                end
            end
            ENC_RUN: begin
                if (tick_q == LAST_TICK) begin
                    tick_d = '0;
                    if (pendingValid_q) begin
                        activeTimes_d  = pendingTimes_q;
                        activeMask_d   = pendingMask_q;
                        pendingValid_d = 1'b0;
                    end else begin
                        state_d = ENC_IDLE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    // State register; reset throws away both the running and waiting vectors.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q        <= ENC_IDLE;
            tick_q         <= '0;
            pendingValid_q <= 1'b0;
            pendingTimes_q <= '0;
            pendingMask_q  <= '0;
            activeTimes_q  <= '0;
            activeMask_q   <= '0;
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            pendingValid_q <= pendingValid_d;
            pendingTimes_q <= pendingTimes_d;
            pendingMask_q  <= pendingMask_d;
            activeTimes_q  <= activeTimes_d;
            activeMask_q   <= activeMask_d;
        end
    end

    assign runState    = (state_q == ENC_RUN);
    assign busy        = runState;
    assign gamma_start = runState && (tick_q == '0);

    // One comparator per lane; gating on runState keeps stale active
    // registers silent while idle.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : gLane
        spike_pulse_gen #(
            .TIME_WIDTH  (TIME_WIDTH),
            .PULSE_WIDTH (PULSE_WIDTH)
        ) uPulse (
            .runEn_i    (runState),
            .laneTime_i (activeTimes_q[laneLsb(i, TIME_WIDTH) +: TIME_WIDTH]),
            .laneMask_i (activeMask_q[i]),
            .tick_i     (tick_q),
            .spike_o    (output_spikes[i])
        );
    end

endmodule

// File: tb/tb_spike_encoder.sv
// ---------------------------------------------------------------------------
// tb_spike_encoder
// Directed bench for spike_encoder at GAMMA=16, PULSE=8, NUM=16.
// ---------------------------------------------------------------------------
module tb_spike_encoder;

    localparam int GAMMA = 16;
    localparam int PULSE = 8;
    localparam int NUM   = 16;
    localparam int TW    = 4;

    logic            aclk;
    logic            rst;
    logic [NUM-1:0]  output_spikes;
    logic            gamma_start;
    logic            busy;

    int checks = 0;
    int errors = 0;

    spike_encoder_if #(.NUM_INPUTS(NUM), .TIME_WIDTH(TW)) inBus ();

    spike_encoder #(
        .GAMMA_CYCLE_WIDTH (GAMMA),
        .PULSE_WIDTH       (PULSE),
        .NUM_INPUTS        (NUM)
    ) dut (
        .aclk          (aclk),
        .rst           (rst),
        .inBus         (inBus.slave),
        .output_spikes (output_spikes),
        .gamma_start   (gamma_start),
        .busy          (busy)
    );

    // Free-running clock, 10 time units per period.
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance one rising edge and settle just past it.
    task automatic applyStimulus();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Walk a gamma cycle from startTick to tick 15, expecting laneBits high on
    // ticks firstTick..lastTick and low otherwise. Ends one edge past tick 15.
    task automatic checkGamma(input string tag, input logic [NUM-1:0] laneBits,
                              input int firstTick, input int lastTick, input int startTick);
        for (int t = startTick; t < GAMMA; t++) begin
            checkOutput($sformatf("%s_spk_t%0d", tag, t), 32'(output_spikes),
                        (t >= firstTick && t <= lastTick) ? 32'(laneBits) : 32'h0);
            checkOutput($sformatf("%s_gs_t%0d", tag, t), 32'(gamma_start), (t == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("%s_busy_t%0d", tag, t), 32'(busy), 32'h1);
            applyStimulus();
        end
    endtask

    initial begin
        rst            = 1'b1;
        inBus.in_valid = 1'b0;
        inBus.in_times = '0;
        inBus.in_mask  = '0;

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("rst_spikes", 32'(output_spikes), 32'h0);
        checkOutput("rst_gamma", 32'(gamma_start), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_ready", 32'(inBus.in_ready), 32'h1);
        rst = 1'b0;
        applyStimulus();
        checkOutput("idle_ready", 32'(inBus.in_ready), 32'h1);
        checkOutput("idle_busy", 32'(busy), 32'h0);

        // Single vector: lane 0 at t=3 -> ticks 3..10
        inBus.in_times          = '0;
        inBus.in_times[0 +: TW] = 4'd3;
        inBus.in_mask           = 16'h0001;
        inBus.in_valid          = 1'b1;
        applyStimulus();
        inBus.in_valid = 1'b0;
        checkOutput("a_ready_after_accept", 32'(inBus.in_ready), 32'h0);
        checkOutput("a_busy_before_run", 32'(busy), 32'h0);
        checkOutput("a_gs_before_run", 32'(gamma_start), 32'h0);
        applyStimulus();
        checkGamma("a", 16'h0001, 3, 10, 0);
        checkOutput("a_busy_after", 32'(busy), 32'h0);
        checkOutput("a_spikes_after", 32'(output_spikes), 32'h0);
        checkOutput("a_ready_after", 32'(inBus.in_ready), 32'h1);

        // Back-to-back: lane 5 at t=12 (truncated to ticks 12..15), then a
        // silent vector. While the second waits, a decoy (lane 1 t=2) is shown
        // and must not be captured.
        inBus.in_times           = '0;
        inBus.in_times[5*TW +: TW] = 4'd12;
        inBus.in_mask            = 16'h0020;
        inBus.in_valid           = 1'b1;
        applyStimulus();
        checkOutput("b_ready_full", 32'(inBus.in_ready), 32'h0);
        inBus.in_times           = '0;
        inBus.in_times[1*TW +: TW] = 4'd2;
        inBus.in_mask            = 16'h0002;
        applyStimulus();
        checkOutput("b_ready_rises", 32'(inBus.in_ready), 32'h1);
        checkOutput("b_gs_t0", 32'(gamma_start), 32'h1);
        checkOutput("b_spk_t0", 32'(output_spikes), 32'h0);
        inBus.in_times = '0;
        inBus.in_mask  = 16'h0000;
        applyStimulus();
        inBus.in_valid = 1'b0;
        checkOutput("b_ready_second", 32'(inBus.in_ready), 32'h0);
        checkGamma("b", 16'h0020, 12, 15, 1);
        checkGamma("c", 16'h0000, 0, -1, 0);
        checkOutput("c_busy_after", 32'(busy), 32'h0);
        checkOutput("c_ready_after", 32'(inBus.in_ready), 32'h1);

        // Reset mid-gamma with lanes 0..3 spiking and a vector pending
        inBus.in_times = '0;
        inBus.in_mask  = 16'h000F;
        inBus.in_valid = 1'b1;
        applyStimulus();
        inBus.in_mask  = 16'h0010;
        applyStimulus();
        applyStimulus();
        inBus.in_valid = 1'b0;
        checkOutput("d_pending_full", 32'(inBus.in_ready), 32'h0);
        for (int k = 0; k < 5; k++) applyStimulus();
        checkOutput("d_spk_t6", 32'(output_spikes), 32'h000F);
        checkOutput("d_busy_t6", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("d_rst_spikes", 32'(output_spikes), 32'h0);
        checkOutput("d_rst_busy", 32'(busy), 32'h0);
        checkOutput("d_rst_gamma", 32'(gamma_start), 32'h0);
        checkOutput("d_rst_ready", 32'(inBus.in_ready), 32'h1);
        applyStimulus();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus();
            checkOutput($sformatf("d_post_spk_%0d", k), 32'(output_spikes), 32'h0);
            checkOutput($sformatf("d_post_busy_%0d", k), 32'(busy), 32'h0);
        end
        checkOutput("d_post_ready", 32'(inBus.in_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
